// File: rtl/tx_pkg.sv
// Shared constants and types for the TX IQ pair source.
// Pair word layout: [11:0] I, [23:12] Q. Three host bytes make one pair.
package tx_pkg;

  localparam int          IQ_PAIR_WIDTH  = 24;
  localparam int          BYTES_PER_PAIR = 3;
  localparam logic [11:0] TONE_Q_OFFSET  = 12'h400;

  typedef enum logic [1:0] {
    PK_B0 = 2'd0,
    PK_B1 = 2'd1,
    PK_B2 = 2'd2
  } pk_state_t;

  typedef struct packed {
    logic [11:0] q;
    logic [11:0] i;
  } iq_pair_t;

  // Q leads I by a quarter turn of the 12-bit phase wheel.
  function automatic iq_pair_t tone_pair(input logic [11:0] phase);
    iq_pair_t p;
    p.i = phase;
    p.q = phase + TONE_Q_OFFSET;
    return p;
  endfunction

endpackage

// File: rtl/tx_pair_source_if.sv
// Host byte stream in, AFE pair-word pop interface out.
// master = host/AFE side, slave = tx_pair_source.
interface tx_pair_source_if;
  import tx_pkg::*;

  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     tx_fifo_req;
  logic [IQ_PAIR_WIDTH-1:0] tx_fifo_data;
  logic                     tx_fifo_empty;

  modport master (
    output in_data, in_valid, tx_fifo_req,
    input  in_ready, tx_fifo_data, tx_fifo_empty
  );

  modport slave (
    input  in_data, in_valid, tx_fifo_req,
    output in_ready, tx_fifo_data, tx_fifo_empty
  );

endinterface

// File: rtl/tx_pair_fifo.sv
// Show-ahead pair FIFO: write visible at head one cycle later, pop advances head same edge.
// Backpressure: push ignored when full, pop ignored when empty; clr wins over both.
module tx_pair_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 24
) (
  input  logic                  tx_fifo_clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_dat,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (level_q == DEPTH_LVL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign head_dat = mem_q[rd_ptr_q];

  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      // Storage contents are left alone; only occupancy is discarded.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      level_d = level_q + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
    end
  end

  always_ff @(posedge tx_fifo_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/tx_pair_source.sv
// Packs host bytes into 24-bit IQ pairs for the AFE TX stage, with a test-tone override.
// Latency: a completed pair is visible one cycle later; in_ready depends only on registered level.
module tx_pair_source #(
  parameter int DEPTH_LOG2    = 4,
  parameter int IQ_PAIR_WIDTH = 24
) (
  input  logic                tx_fifo_clk,
  input  logic                reset_n,
  tx_pair_source_if.slave     bus,
  input  logic                flush,
  input  logic                tone_en,
  input  logic [11:0]         tone_step,
  output logic [DEPTH_LOG2:0] level,
  output logic [15:0]         starve_cnt
);
  import tx_pkg::*;

  pk_state_t                  pk_state_q, pk_state_d;
  logic [7:0]                 b0_q, b0_d;
  logic [7:0]                 b1_q, b1_d;
  logic [11:0]                phase_q, phase_d;
  logic [15:0]                starve_q, starve_d;

  logic                       accept;
  logic                       push;
  logic                       pop;
  logic [BYTES_PER_PAIR*8-1:0] pack_word;
  logic [IQ_PAIR_WIDTH-1:0]   head_dat;
  logic                       fifo_full;
  logic                       fifo_empty;
  iq_pair_t                   tone_word;

  assign bus.in_ready = ~fifo_full;
  assign accept       = bus.in_valid & ~fifo_full;
  assign pack_word    = {bus.in_data, b1_q, b0_q};
  assign pop          = bus.tx_fifo_req & ~tone_en;

  always_comb begin
    pk_state_d = pk_state_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    phase_d    = phase_q;
    starve_d   = starve_q;
    push       = 1'b0;
    if (flush) begin
      pk_state_d = PK_B0;
      phase_d    = '0;
    end else begin
      if (accept) begin
        unique case (pk_state_q)
          PK_B0: begin
            b0_d       = bus.in_data;
            pk_state_d = PK_B1;
          end
          PK_B1: begin
            b1_d       = bus.in_data;
            pk_state_d = PK_B2;
          end
          PK_B2: begin
            push       = 1'b1;
            pk_state_d = PK_B0;
          end
          default: pk_state_d = PK_B0;
        endcase
      end
      if (tone_en && bus.tx_fifo_req) begin
        phase_d = phase_q + tone_step;
      end
    end
    // Starvation is independent of flush: it tracks what the AFE saw this cycle.
    if (!tone_en && fifo_empty && (starve_q != 16'hFFFF)) begin
      starve_d = starve_q + 16'd1;
    end
  end

  always_ff @(posedge tx_fifo_clk or negedge reset_n) begin
    if (!reset_n) begin
      pk_state_q <= PK_B0;
      b0_q       <= '0;
      b1_q       <= '0;
      phase_q    <= '0;
      starve_q   <= '0;
    end else begin
      pk_state_q <= pk_state_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      phase_q    <= phase_d;
      starve_q   <= starve_d;
    end
  end

  tx_pair_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (IQ_PAIR_WIDTH)
  ) u_fifo (
    .tx_fifo_clk (tx_fifo_clk),
    .reset_n     (reset_n),
    .clr         (flush),
    .push        (push),
    .push_dat    (pack_word),
    .pop         (pop),
    .head_dat    (head_dat),
    .level       (level),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign tone_word         = tone_pair(phase_q);
  assign bus.tx_fifo_data  = tone_en ? tone_word : head_dat;
  assign bus.tx_fifo_empty = ~tone_en & fifo_empty;
  assign starve_cnt        = starve_q;

endmodule

// File: doc/tx_pair_source.md
TX_PAIR_SOURCE -- requirements
Module: tx_pair_source

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 IQ pair words.
REQ-002 Parameter IQ_PAIR_WIDTH, default 24, pair word width; only 24 supported (3 bytes per pair).
REQ-003 tx_fifo_clk  input  1  sole clock; all state changes on posedge. Reset: reset_n, asynchronous, active-low.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in_data  input  8  host byte stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  byte accepted when in_valid & in_ready at posedge.
REQ-008 flush  input  1  synchronous clear of FIFO, packer and tone phase.
REQ-009 tone_en  input  1  1 = internal test tone replaces FIFO output.
REQ-010 tone_step  input  12  tone phase increment per pop.
REQ-011 tx_fifo_req  input  1  pop request from the AFE TX stage.
REQ-012 tx_fifo_data  output  24  head pair word, show-ahead; [11:0] I, [23:12] Q.
REQ-013 tx_fifo_empty  output  1  no pair available.
REQ-014 level  output  DEPTH_LOG2+1  stored word count.
REQ-015 starve_cnt  output  16  saturating count of starved cycles.

Function
REQ-016 Packer FSM states B0, B1, B2; accepted byte stored to [7:0], [15:8], [23:16] respectively; B0->B1->B2->B0 on each accepted byte.
REQ-017 Acceptance in B2 writes the assembled 24-bit word into the FIFO on that same edge; word visible at tx_fifo_data next cycle if FIFO was empty.
REQ-018 in_ready = ~full (level == 2**DEPTH_LOG2), decoded from registered level only; no combinational path from tx_fifo_req.
REQ-019 Pop: posedge with tx_fifo_req=1, tone_en=0, empty=0 advances read pointer; req while empty ignored, no pointer change.
REQ-020 Simultaneous push and pop: level unchanged, both pointers advance.
REQ-021 Pointers wrap modulo 2**DEPTH_LOG2; level is exact 0..2**DEPTH_LOG2.
REQ-022 tx_fifo_empty = (level == 0) when tone_en=0; tx_fifo_data = head word (don't-care content when empty, but stable).
REQ-023 tone_en=1: tx_fifo_empty=0; tx_fifo_data = {phase+12'h400, phase} (mod 4096); phase += tone_step on each posedge with tx_fifo_req=1; FIFO not popped, packer/writes continue.
REQ-024 tone_en=0: phase holds.
REQ-025 flush=1: level, pointers, packer state (-> B0), phase cleared next edge; flush wins over simultaneous push, byte accept and pop; partial packed bytes discarded.
REQ-026 starve_cnt increments each posedge with tone_en=0 and level==0, saturates at 16'hFFFF; cleared only by reset.

Reset
REQ-027 reset_n low: level=0, pointers=0, packer=B0, phase=0, starve_cnt=0; outputs tx_fifo_empty=1, in_ready=1, tx_fifo_data=0 (storage reset), level=0.
REQ-028 Reset mid-packet or mid-burst discards all content; first byte after release goes to [7:0].

Structure
REQ-029 Shared package tx_pkg: IQ_PAIR_WIDTH=24, BYTES_PER_PAIR=3, TONE_Q_OFFSET=12'h400, packer state encoding.
REQ-030 One sub-module tx_pair_fifo: storage, pointers, level, full/empty; packer, tone and starve counter in top.

Verification
REQ-031 Bytes 01 02 03 04 05 06 with no req -> level=2, tx_fifo_data=24'h030201; one req edge -> 24'h060504, level=1.
REQ-032 Push 16 pairs (48 bytes) -> in_ready=0 at level=16; 49th byte held; one pop -> in_ready=1, byte accepted.
REQ-033 Level=1, third byte and req on same edge -> level stays 1, data = new word.
REQ-034 Bytes AA BB then flush with in_valid=1 -> level=0, packer B0; next bytes 11 22 33 -> word 24'h332211.
REQ-035 tone_en=1, tone_step=12'h100, 3 req edges -> tx_fifo_data = {12'h700, 12'h300}, tx_fifo_empty=0, FIFO level unchanged.
REQ-036 Empty FIFO, tone_en=0 for 70000 cycles -> starve_cnt=16'hFFFF; reset_n pulse mid-run -> all outputs at REQ-027 values.
